instr_fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the unified 256x16 Memory block. Owns the program counter and drives the memory address while fetch holds the port. Captures the combinationally-read instruction word into a small prefetch queue, which feeds decode through a valid/ready handshake. Handles branch redirect/flush and HALT.

---
 rtl/instr_fetch_unit.sv | 114 +++++++++++
 tb/tb_instr_fetch_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// instr_fetch_unit : PC owner and prefetch queue feeding decode; optional
// HALT-opcode stop enabled by defining IFETCH_HALT_DETECT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
    parameter int              QUEUE_DEPTH = 4,
    parameter int              ADDR_W      = 8,
    parameter int              DATA_W      = 16,
    parameter logic [ADDR_W-1:0] RESET_PC  = 8'd0
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            mem_grant,
    output logic [ADDR_W-1:0]               mem_addr,
    input  logic [DATA_W-1:0]               mem_data,
    input  logic                            redirect_valid,
    input  logic [ADDR_W-1:0]               redirect_pc,
    output logic                            instr_valid,
    input  logic                            instr_ready,
    output logic [DATA_W-1:0]               instr,
    output logic [ADDR_W-1:0]               instr_pc,
    output logic                            halted,
    output logic [$clog2(QUEUE_DEPTH):0]    queue_level
);

    localparam int                PTR_W  = $clog2(QUEUE_DEPTH);
    localparam int                LVL_W  = PTR_W + 1;
    localparam logic [LVL_W-1:0]  c_full = LVL_W'(QUEUE_DEPTH);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [PTR_W-1:0]    r_head;
    logic [PTR_W-1:0]    r_tail;
    logic [LVL_W-1:0]    r_level;
    logic [DATA_W-1:0]   r_data [QUEUE_DEPTH];
    logic [ADDR_W-1:0]   r_pcq  [QUEUE_DEPTH];

    logic w_pop;
    logic w_fetch;
    logic w_halt_hit;

    assign instr_valid = (r_level != '0);
    assign w_pop       = instr_valid & instr_ready;
    assign w_fetch     = (r_state == ST_RUN) & mem_grant & ~redirect_valid &
                         ((r_level != c_full) | w_pop);

`ifdef IFETCH_HALT_DETECT_EN
    // HALT opcode normally supplied by config.v; fallback keeps the file standalone.
`ifndef HALT
`define HALT 5'h1F
`endif
    assign w_halt_hit = (mem_data[DATA_W-1:DATA_W-5] == `HALT);
    assign halted     = (r_state == ST_HALT);
`else
    assign w_halt_hit = 1'b0;
    assign halted     = 1'b0;
`endif

    assign mem_addr    = r_pc;
    assign instr       = r_data[r_head];
    assign instr_pc    = r_pcq[r_head];
    assign queue_level = r_level;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
            r_head  <= '0;
            r_tail  <= '0;
            r_level <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                r_data[i] <= '0;
                r_pcq[i]  <= '0;
            end
        end else if (redirect_valid) begin
            // Flush wins over any same-cycle pop or fetch.
            r_state <= ST_RUN;
            r_pc    <= redirect_pc;
            r_head  <= '0;
            r_tail  <= '0;
            r_level <= '0;
        end else begin
            if (w_fetch) begin
                r_data[r_tail] <= mem_data;
                r_pcq[r_tail]  <= r_pc;
                r_tail         <= r_tail + 1'b1;
                if (w_halt_hit) begin
                    r_state <= ST_HALT;
                end else begin
                    r_pc <= r_pc + 1'b1;
                end
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_fetch, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// tb_instr_fetch_unit : directed self-checking bench for instr_fetch_unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_grant;
    logic [7:0]  mem_addr;
    logic [15:0] mem_data;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        halted;
    logic [2:0]  queue_level;

    logic [15:0] mem [256];
    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    assign mem_data = mem[mem_addr];

    instr_fetch_unit dut (
        .clock          (clock),
        .reset          (reset),
        .mem_grant      (mem_grant),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .halted         (halted),
        .queue_level    (queue_level)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [7:0]  fe_pc   [4];
        logic [15:0] fe_word [4];
        fe_pc   = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        fe_word = '{16'h10FF, 16'h1100, 16'h1001, 16'h1002};

        for (int i = 0; i < 256; i++) mem[i] = 16'(16'h1001 + i);
        mem[23] = 16'hF800;

        reset = 1'b1; mem_grant = 1'b1; instr_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 8'h00;
        #2;
        chk("rst_level",  32'(queue_level), 32'd0);
        chk("rst_valid",  32'(instr_valid), 32'd0);
        chk("rst_instr",  32'(instr),       32'd0);
        chk("rst_pc",     32'(instr_pc),    32'd0);
        chk("rst_halted", 32'(halted),      32'd0);
        chk("rst_addr",   32'(mem_addr),    32'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        // Streaming: one word per cycle, first visible after the first edge.
        for (int i = 0; i < 6; i++) begin
            step();
            chk("stream_valid", 32'(instr_valid), 32'd1);
            chk("stream_instr", 32'(instr),       32'(16'h1001 + i));
            chk("stream_pc",    32'(instr_pc),    32'(i));
        end

        // Mid-run reset discards the queue; then fill without decode.
        instr_ready = 1'b0;
        reset = 1'b1; #1;
        chk("midrst_level", 32'(queue_level), 32'd0);
        chk("midrst_valid", 32'(instr_valid), 32'd0);
        step();
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("fill_level", 32'(queue_level), 32'(i));
            chk("fill_addr",  32'(mem_addr),    32'(i));
        end
        step();
        chk("full_level", 32'(queue_level), 32'd4);
        chk("full_addr",  32'(mem_addr),    32'd4);
        chk("full_instr", 32'(instr),       32'h1001);
        chk("full_pc",    32'(instr_pc),    32'd0);
        instr_ready = 1'b1;
        step();
        chk("fullpop_level", 32'(queue_level), 32'd4);
        chk("fullpop_pc",    32'(instr_pc),    32'd1);
        chk("fullpop_instr", 32'(instr),       32'h1002);
        chk("fullpop_addr",  32'(mem_addr),    32'd5);

        // Grant stall at PC 7 while the queue drains.
        step();
        chk("pre_stall_pc", 32'(instr_pc), 32'd2);
        step();
        chk("pre_stall_pc", 32'(instr_pc), 32'd3);
        chk("pre_stall_addr", 32'(mem_addr), 32'd7);
        mem_grant = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_addr",  32'(mem_addr),    32'd7);
            chk("stall_level", 32'(queue_level), 32'(3 - k));
            chk("stall_pc",    32'(instr_pc),    32'(4 + k));
        end
        mem_grant = 1'b1;
        step();
        chk("resume_pc",    32'(instr_pc),    32'd7);
        chk("resume_level", 32'(queue_level), 32'd1);
        chk("resume_addr",  32'(mem_addr),    32'd8);
        step();
        chk("resume_pc2",   32'(instr_pc),    32'd8);

        // Queue holding PCs 3..5, then redirect to 0x0C.
        instr_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 8'h03;
        step();
        redirect_valid = 1'b0;
        step(); step(); step();
        chk("q35_level", 32'(queue_level), 32'd3);
        chk("q35_pc",    32'(instr_pc),    32'd3);
        chk("q35_addr",  32'(mem_addr),    32'd6);
        redirect_valid = 1'b1; redirect_pc = 8'h0C; instr_ready = 1'b1;
        step();
        redirect_valid = 1'b0;
        chk("redir_level", 32'(queue_level), 32'd0);
        chk("redir_valid", 32'(instr_valid), 32'd0);
        chk("redir_addr",  32'(mem_addr),    32'h0C);
        step();
        chk("redir_first_valid", 32'(instr_valid), 32'd1);
        chk("redir_first_pc",    32'(instr_pc),    32'h0C);
        chk("redir_first_instr", 32'(instr),       32'h100D);
        step();
        chk("redir_second_pc",   32'(instr_pc),    32'h0D);

        // PC wrap from 0xFE.
        redirect_valid = 1'b1; redirect_pc = 8'hFE;
        step();
        redirect_valid = 1'b0;
        chk("wrap_start_addr", 32'(mem_addr), 32'hFE);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("wrap_pc",    32'(instr_pc), 32'(fe_pc[i]));
            chk("wrap_instr", 32'(instr),    32'(fe_word[i]));
        end

        // HALT word at address 23.
        redirect_valid = 1'b1; redirect_pc = 8'd21;
        step();
        redirect_valid = 1'b0;
        step();
        chk("halt_pre_pc", 32'(instr_pc), 32'd21);
        step();
        chk("halt_pre_pc2",   32'(instr_pc), 32'd22);
        chk("halt_pre_addr",  32'(mem_addr), 32'd23);
        step();
        chk("halt_word_pc",    32'(instr_pc), 32'd23);
        chk("halt_word_instr", 32'(instr),    32'hF800);
`ifdef IFETCH_HALT_DETECT_EN
        chk("halt_set",  32'(halted),   32'd1);
        chk("halt_addr", 32'(mem_addr), 32'd23);
        step();
        chk("halt_drain_valid", 32'(instr_valid), 32'd0);
        chk("halt_drain_level", 32'(queue_level), 32'd0);
        chk("halt_hold_addr",   32'(mem_addr),    32'd23);
        step();
        chk("halt_hold_addr2",  32'(mem_addr),    32'd23);
        chk("halt_still",       32'(halted),      32'd1);
        chk("halt_no_fetch",    32'(queue_level), 32'd0);
        redirect_valid = 1'b1; redirect_pc = 8'h00;
        step();
        redirect_valid = 1'b0;
        chk("halt_clear",       32'(halted),   32'd0);
        chk("halt_clear_addr",  32'(mem_addr), 32'd0);
        step();
        chk("restart_valid", 32'(instr_valid), 32'd1);
        chk("restart_pc",    32'(instr_pc),    32'd0);
        chk("restart_addr",  32'(mem_addr),    32'd1);
`else
        chk("nohalt_halted", 32'(halted),   32'd0);
        chk("nohalt_addr",   32'(mem_addr), 32'd24);
        step();
        chk("nohalt_pc",     32'(instr_pc), 32'd24);
        chk("nohalt_addr2",  32'(mem_addr), 32'd25);
        chk("nohalt_halted2", 32'(halted),  32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
